i2c_target_fsm: RTL and testbench

Synthesizable I2C target (slave) that answers the two-byte sensor read issued by the `i2c_fsm` master: addressed read returns a 16-bit word (MSB first, then LSB), addressed write delivers bytes to a local strobe interface. Sits at the far end of the same open-drain SCL/SDA bus as `i2c_fsm`, with the same pad-style port split (`*_pad_i`, `*_pad_o`, `*_padoen_o`).

---
 rtl/i2c_pkg.sv | 34 +++
 rtl/i2c_sync_edge.sv | 52 +++++
 rtl/i2c_target_fsm.sv | 262 ++++++++++++++++++++++++++
 tb/tb_i2c_target_fsm.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, ACK/NACK bus
// levels, R/W bit position, widths and a byte-select helper.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 4;

  // SDA levels as seen on the bus; driving low is ACK
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Position of the R/W flag in the address byte (1 = read)
  localparam int unsigned RW_BIT = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_WAIT_STOP
  } state_e;

  // Select MSB (lsb=0) or LSB (lsb=1) byte of the held word
  function automatic logic [BYTE_W-1:0] pick_byte(input logic [WORD_W-1:0] word,
                                                  input logic lsb);
    return lsb ? word[BYTE_W-1:0] : word[WORD_W-1:BYTE_W];
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizers for SCL/SDA plus edge and bus-condition pulses.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   scl_line        raw SCL bus level
//   sda_line        raw SDA bus level
//   sda             synchronized SDA level
//   scl_rise_c      SCL rising edge (one cycle)
//   scl_fall_c      SCL falling edge (one cycle)
//   start_c         START: SDA falls while SCL high
//   stop_c          STOP: SDA rises while SCL high
module i2c_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic scl_line,
  input  logic sda_line,
  output logic sda,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_prev;
  logic       sda_prev;
  logic       scl;

  // Reset to the idle bus level so no edge is seen after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_line};
      sda_sync <= {sda_sync[0], sda_line};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl = scl_sync[1];
  assign sda = sda_sync[1];

  assign scl_rise_c = scl & ~scl_prev;
  assign scl_fall_c = ~scl & scl_prev;
  assign start_c    = scl & scl_prev & sda_prev & ~sda;
  assign stop_c     = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_target_fsm.sv
// I2C target answering a two-byte word read (MSB then LSB, wrapping) and
// delivering written bytes on a strobe interface.
// Optional macro I2C_TARGET_STRETCH_EN: hold SCL low after the read address
// ACK until rd_vld_i, latching rd_data_i then instead of at rd_req_o.
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   scl_pad_i/o, scl_padoen_o  SCL pad (drive value 0, enable active low)
//   sda_pad_i/o, sda_padoen_o  SDA pad (drive value 0, enable active low)
//   rd_data_i, rd_vld_i      word returned on read and its valid
//   rd_req_o                 one-cycle pulse when a read is addressed
//   wr_data_o, wr_stb_o      last written byte and its one-cycle strobe
//   busy_o                   high from matched address ACK to START/STOP
module i2c_target_fsm
  import i2c_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR = 7'h48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_pad_i,
  output logic              scl_pad_o,
  output logic              scl_padoen_o,
  input  logic              sda_pad_i,
  output logic              sda_pad_o,
  output logic              sda_padoen_o,
  input  logic [WORD_W-1:0] rd_data_i,
  input  logic              rd_vld_i,
  output logic              rd_req_o,
  output logic [BYTE_W-1:0] wr_data_o,
  output logic              wr_stb_o,
  output logic              busy_o
);

  logic sda, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_sync_edge u_sync (
    .clk        (clk),
    .rst        (rst),
    .scl_line   (scl_pad_i),
    .sda_line   (sda_pad_i),
    .sda        (sda),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  state_e              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [BYTE_W-1:0]   rx_sh, rx_nxt, tx_sh, tx_nxt, wr_data_nxt;
  logic [WORD_W-1:0]   word, word_nxt;
  logic                rw, rw_nxt, lsb_sel, lsb_nxt, mack, mack_nxt;
  logic                sda_oe, sda_oe_nxt, scl_oe, scl_oe_nxt;
  logic                rd_req_nxt, wr_stb_nxt, busy_nxt;
  logic                do_load;
  logic [BYTE_W-1:0]   load_byte;
  logic                byte_done_c, addr_hit_c;

  assign byte_done_c = (bit_cnt == CNT_W'(BYTE_W));
  assign addr_hit_c  = (rx_sh[BYTE_W-1:1] == ADDR) && (rx_sh[BYTE_W-1:1] != '0);

  assign scl_pad_o    = 1'b0;
  assign sda_pad_o    = 1'b0;
  assign scl_padoen_o = scl_oe;
  assign sda_padoen_o = sda_oe;

`ifndef I2C_TARGET_STRETCH_EN
  logic unused_rd_vld;
  assign unused_rd_vld = rd_vld_i;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; START/STOP override data-edge handling
  always_comb begin
    state_nxt = state;
    if (start_c) begin
      state_nxt = ST_ADDR;
    end else if (stop_c) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_ADDR:
          if (scl_fall_c && byte_done_c) state_nxt = addr_hit_c ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:
          if (!rw) begin
            if (scl_fall_c) state_nxt = ST_WR_DATA;
          end else begin
`ifdef I2C_TARGET_STRETCH_EN
            if (!scl_oe && rd_vld_i) state_nxt = ST_RD_DATA;
`else
            if (scl_fall_c) state_nxt = ST_RD_DATA;
`endif
          end
        ST_WR_DATA:
          if (scl_fall_c && byte_done_c) state_nxt = ST_WR_ACK;
        ST_WR_ACK:
          if (scl_fall_c) state_nxt = ST_WR_DATA;
        ST_RD_DATA:
          if (scl_fall_c && byte_done_c) state_nxt = ST_RD_ACK;
        ST_RD_ACK:
          if (scl_fall_c) state_nxt = (mack == ACK) ? ST_RD_DATA : ST_WAIT_STOP;
        default: state_nxt = state;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    bit_cnt_nxt = bit_cnt;
    rx_nxt      = rx_sh;
    tx_nxt      = tx_sh;
    word_nxt    = word;
    rw_nxt      = rw;
    lsb_nxt     = lsb_sel;
    mack_nxt    = mack;
    sda_oe_nxt  = sda_oe;
    scl_oe_nxt  = scl_oe;
    rd_req_nxt  = 1'b0;
    wr_stb_nxt  = 1'b0;
    wr_data_nxt = wr_data_o;
    busy_nxt    = busy_o;
    do_load     = 1'b0;
    load_byte   = '0;
`ifndef I2C_TARGET_STRETCH_EN
    scl_oe_nxt = 1'b1;
    if (rd_req_o) word_nxt = rd_data_i;
`endif
    if (start_c) begin
      bit_cnt_nxt = '0;
      sda_oe_nxt  = 1'b1;
      scl_oe_nxt  = 1'b1;
      busy_nxt    = 1'b0;
    end else if (stop_c) begin
      sda_oe_nxt = 1'b1;
      scl_oe_nxt = 1'b1;
      busy_nxt   = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_WR_DATA: begin
          if (scl_rise_c && !byte_done_c) begin
            rx_nxt      = {rx_sh[BYTE_W-2:0], sda};
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
          end else if (scl_fall_c && byte_done_c) begin
            if (state == ST_WR_DATA) begin
              sda_oe_nxt  = ACK;
              wr_data_nxt = rx_sh;
              wr_stb_nxt  = 1'b1;
            end else if (addr_hit_c) begin
              sda_oe_nxt = ACK;
              rw_nxt     = rx_sh[RW_BIT];
              rd_req_nxt = rx_sh[RW_BIT];
              busy_nxt   = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (!rw) begin
            if (scl_fall_c) begin
              sda_oe_nxt  = 1'b1;
              bit_cnt_nxt = '0;
            end
          end else begin
`ifdef I2C_TARGET_STRETCH_EN
            // Hold SCL after the ACK until the word is valid
            if (!scl_oe) begin
              if (rd_vld_i) begin
                word_nxt  = rd_data_i;
                lsb_nxt   = 1'b0;
                do_load   = 1'b1;
                load_byte = pick_byte(rd_data_i, 1'b0);
              end
            end else if (scl_fall_c) begin
              scl_oe_nxt = 1'b0;
            end
`else
            if (scl_fall_c) begin
              lsb_nxt   = 1'b0;
              do_load   = 1'b1;
              load_byte = pick_byte(word, 1'b0);
            end
`endif
          end
        end
        ST_WR_ACK:
          if (scl_fall_c) begin
            sda_oe_nxt  = 1'b1;
            bit_cnt_nxt = '0;
          end
        ST_RD_DATA: begin
`ifdef I2C_TARGET_STRETCH_EN
          scl_oe_nxt = 1'b1;
`endif
          if (scl_fall_c) begin
            if (byte_done_c) begin
              sda_oe_nxt = 1'b1;
            end else begin
              sda_oe_nxt  = tx_sh[BYTE_W-1];
              tx_nxt      = {tx_sh[BYTE_W-2:0], 1'b0};
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise_c) begin
            mack_nxt = sda;
          end else if (scl_fall_c && (mack == ACK)) begin
            // Alternate bytes of the same latched word
            lsb_nxt   = ~lsb_sel;
            do_load   = 1'b1;
            load_byte = pick_byte(word, ~lsb_sel);
          end
        end
        default: ;
      endcase
      // Put bit 7 of a new byte on SDA; the rest wait in tx_sh
      if (do_load) begin
        sda_oe_nxt  = load_byte[BYTE_W-1];
        tx_nxt      = {load_byte[BYTE_W-2:0], 1'b0};
        bit_cnt_nxt = CNT_W'(1);
      end
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      rx_sh     <= '0;
      tx_sh     <= '0;
      word      <= '0;
      rw        <= 1'b0;
      lsb_sel   <= 1'b0;
      mack      <= NACK;
      sda_oe    <= 1'b1;
      scl_oe    <= 1'b1;
      rd_req_o  <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_data_o <= '0;
      busy_o    <= 1'b0;
    end else begin
      bit_cnt   <= bit_cnt_nxt;
      rx_sh     <= rx_nxt;
      tx_sh     <= tx_nxt;
      word      <= word_nxt;
      rw        <= rw_nxt;
      lsb_sel   <= lsb_nxt;
      mack      <= mack_nxt;
      sda_oe    <= sda_oe_nxt;
      scl_oe    <= scl_oe_nxt;
      rd_req_o  <= rd_req_nxt;
      wr_stb_o  <= wr_stb_nxt;
      wr_data_o <= wr_data_nxt;
      busy_o    <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_target_fsm.sv
// Bench for i2c_target_fsm: bit-banged open-drain master, table of byte-level
// bus operations with expected responses, plus hand-written corner sequences.
module tb_i2c_target_fsm;
  import i2c_pkg::*;

  localparam int H = 5;  // quarter bit period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] rd_data = 16'h1A2B;
  logic        rd_vld = 1'b1;

  logic        scl_pad_o, scl_padoen_o, sda_pad_o, sda_padoen_o;
  logic        rd_req_o, wr_stb_o, busy_o;
  logic [7:0]  wr_data_o;
  logic        scl_bus, sda_bus;

  assign scl_bus = scl_m & (scl_padoen_o | scl_pad_o);
  assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

  i2c_target_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .scl_pad_i    (scl_bus),
    .scl_pad_o    (scl_pad_o),
    .scl_padoen_o (scl_padoen_o),
    .sda_pad_i    (sda_bus),
    .sda_pad_o    (sda_pad_o),
    .sda_padoen_o (sda_padoen_o),
    .rd_data_i    (rd_data),
    .rd_vld_i     (rd_vld),
    .rd_req_o     (rd_req_o),
    .wr_data_o    (wr_data_o),
    .wr_stb_o     (wr_stb_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int req_cnt = 0, stb_cnt = 0, width_err = 0, scl_low_seen = 0, sda_low_cnt = 0;
  logic prev_req = 1'b0, prev_stb = 1'b0;

  // Pulse counting and width monitoring
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_req && rd_req_o) width_err++;
      if (prev_stb && wr_stb_o) width_err++;
      if (rd_req_o && !prev_req) req_cnt++;
      if (wr_stb_o && !prev_stb) stb_cnt++;
      if (!scl_padoen_o) scl_low_seen++;
      if (!sda_padoen_o) sda_low_cnt++;
    end
    prev_req = rd_req_o;
    prev_stb = wr_stb_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_scl_high();
    int t = 0;
    while (scl_bus !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) check("scl_release_timeout", 32'(scl_bus), 32'd1);
  endtask

  task automatic put_bit(input logic b);
    wait_clk(H); sda_m = b; wait_clk(H);
    scl_m = 1'b1; wait_scl_high(); wait_clk(2*H);
    scl_m = 1'b0;
  endtask

  task automatic get_bit(output logic b);
    wait_clk(H); sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_scl_high(); wait_clk(H);
    b = sda_bus; wait_clk(H);
    scl_m = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic rd_byte(input logic mack, output logic [7:0] d);
    for (int i = 7; i >= 0; i--) get_bit(d[i]);
    put_bit(mack);
  endtask

  task automatic i2c_start();
    wait_clk(H); sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(2*H);
    sda_m = 1'b0; wait_clk(2*H);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(H); sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b1; wait_clk(2*H);
    sda_m = 1'b1; wait_clk(2*H);
  endtask

  typedef enum logic [1:0] {OP_START, OP_STOP, OP_WR, OP_RD} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] data;      // byte written, or expected byte read
    logic       mack;      // master ACK level after a read byte
    logic       exp_ack;   // expected target ACK level after a write byte
    logic       exp_busy;
    int         exp_stb;   // cumulative wr_stb_o pulses
    int         exp_req;   // cumulative rd_req_o pulses
    logic [7:0] exp_wr;
    logic       quiet;     // target must never pull SDA during this op
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input op_e op, input logic [7:0] data, input logic mack,
                              input logic exp_ack, input logic exp_busy, input int exp_stb,
                              input int exp_req, input logic [7:0] exp_wr, input logic quiet);
    vec_t v;
    v.op = op; v.data = data; v.mack = mack; v.exp_ack = exp_ack; v.exp_busy = exp_busy;
    v.exp_stb = exp_stb; v.exp_req = exp_req; v.exp_wr = exp_wr; v.quiet = quiet;
    vecs.push_back(v);
  endfunction

  initial begin
    logic       ack;
    logic [7:0] d;
    int         req0, sda0;

    // Read 0x91: MSB acked, LSB nacked
    add(OP_START, 8'h00, 1'b0, 1'b0, 1'b0, 0, 0, 8'h00, 1'b0);
    add(OP_WR,    8'h91, 1'b0, 1'b0, 1'b1, 0, 1, 8'h00, 1'b0);
    add(OP_RD,    8'h1A, 1'b0, 1'b0, 1'b1, 0, 1, 8'h00, 1'b0);
    add(OP_RD,    8'h2B, 1'b1, 1'b0, 1'b1, 0, 1, 8'h00, 1'b0);
    add(OP_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 0, 1, 8'h00, 1'b1);
    // Write 0x90, 0x01, 0x60
    add(OP_START, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1, 8'h00, 1'b1);
    add(OP_WR,    8'h90, 1'b0, 1'b0, 1'b1, 0, 1, 8'h00, 1'b0);
    add(OP_WR,    8'h01, 1'b0, 1'b0, 1'b1, 1, 1, 8'h01, 1'b0);
    add(OP_WR,    8'h60, 1'b0, 1'b0, 1'b1, 2, 1, 8'h60, 1'b0);
    add(OP_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 2, 1, 8'h60, 1'b0);
    // Wrong address 0x49: ignored until STOP
    add(OP_START, 8'h00, 1'b0, 1'b0, 1'b0, 2, 1, 8'h60, 1'b1);
    add(OP_WR,    8'h92, 1'b0, 1'b1, 1'b0, 2, 1, 8'h60, 1'b1);
    add(OP_WR,    8'h55, 1'b0, 1'b1, 1'b0, 2, 1, 8'h60, 1'b1);
    add(OP_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 2, 1, 8'h60, 1'b1);
    // General call is not acknowledged
    add(OP_START, 8'h00, 1'b0, 1'b0, 1'b0, 2, 1, 8'h60, 1'b1);
    add(OP_WR,    8'h00, 1'b0, 1'b1, 1'b0, 2, 1, 8'h60, 1'b1);
    add(OP_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 2, 1, 8'h60, 1'b1);
    // Write 0x00, repeated START, then read
    add(OP_START, 8'h00, 1'b0, 1'b0, 1'b0, 2, 1, 8'h60, 1'b1);
    add(OP_WR,    8'h90, 1'b0, 1'b0, 1'b1, 2, 1, 8'h60, 1'b0);
    add(OP_WR,    8'h00, 1'b0, 1'b0, 1'b1, 3, 1, 8'h00, 1'b0);
    add(OP_START, 8'h00, 1'b0, 1'b0, 1'b0, 3, 1, 8'h00, 1'b0);
    add(OP_WR,    8'h91, 1'b0, 1'b0, 1'b1, 3, 2, 8'h00, 1'b0);
    add(OP_RD,    8'h1A, 1'b0, 1'b0, 1'b1, 3, 2, 8'h00, 1'b0);
    add(OP_RD,    8'h2B, 1'b1, 1'b0, 1'b1, 3, 2, 8'h00, 1'b0);
    add(OP_STOP,  8'h00, 1'b0, 1'b0, 1'b0, 3, 2, 8'h00, 1'b1);

    // Reset values
    wait_clk(4);
    check("rst_scl_padoen", 32'(scl_padoen_o), 32'd1);
    check("rst_sda_padoen", 32'(sda_padoen_o), 32'd1);
    check("rst_scl_pad_o",  32'(scl_pad_o),    32'd0);
    check("rst_sda_pad_o",  32'(sda_pad_o),    32'd0);
    check("rst_rd_req",     32'(rd_req_o),     32'd0);
    check("rst_wr_stb",     32'(wr_stb_o),     32'd0);
    check("rst_wr_data",    32'(wr_data_o),    32'h00);
    check("rst_busy",       32'(busy_o),       32'd0);
    rst = 1'b0;
    wait_clk(4);

    for (int i = 0; i < vecs.size(); i++) begin
      sda0 = sda_low_cnt;
      case (vecs[i].op)
        OP_START: i2c_start();
        OP_STOP:  i2c_stop();
        OP_WR: begin
          wr_byte(vecs[i].data, ack);
          check($sformatf("v%0d_ack", i), 32'(ack), 32'(vecs[i].exp_ack));
        end
        default: begin
          rd_byte(vecs[i].mack, d);
          check($sformatf("v%0d_rd_byte", i), 32'(d), 32'(vecs[i].data));
        end
      endcase
      wait_clk(2);
      check($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].exp_busy));
      check($sformatf("v%0d_stb_cnt", i), 32'(stb_cnt), 32'(vecs[i].exp_stb));
      check($sformatf("v%0d_req_cnt", i), 32'(req_cnt), 32'(vecs[i].exp_req));
      check($sformatf("v%0d_wr_data", i), 32'(wr_data_o), 32'(vecs[i].exp_wr));
      if (vecs[i].quiet)
        check($sformatf("v%0d_sda_quiet", i), 32'(sda_low_cnt - sda0), 32'd0);
      if (vecs[i].op == OP_STOP)
        check($sformatf("v%0d_sda_released", i), 32'(sda_padoen_o), 32'd1);
    end

    // Three-byte read wraps to MSB; word change after latch is invisible
    req0 = req_cnt;
    i2c_start();
    wr_byte(8'h91, ack);
    check("wrap_addr_ack", 32'(ack), 32'd0);
    rd_data = 16'hFFFF;
    rd_byte(1'b0, d); check("wrap_byte0", 32'(d), 32'h1A);
    rd_byte(1'b0, d); check("wrap_byte1", 32'(d), 32'h2B);
    rd_byte(1'b1, d); check("wrap_byte2", 32'(d), 32'h1A);
    i2c_stop();
    wait_clk(2);
    check("wrap_req_once", 32'(req_cnt - req0), 32'd1);
    check("wrap_idle_busy", 32'(busy_o), 32'd0);
    rd_data = 16'h1A2B;

    // Reset while the MSB's bit 7 (a 0) is being driven
    i2c_start();
    wr_byte(8'h91, ack);
    check("rstmid_addr_ack", 32'(ack), 32'd0);
    wait_clk(H);
    check("rstmid_msb_driven", 32'(sda_padoen_o), 32'd0);
    rst = 1'b1;
    wait_clk(1);
    check("rstmid_sda_released", 32'(sda_padoen_o), 32'd1);
    check("rstmid_busy", 32'(busy_o), 32'd0);
    check("rstmid_state", 32'(dut.state), 32'(ST_IDLE));
    rst = 1'b0;
    sda_m = 1'b1; scl_m = 1'b1;
    wait_clk(4*H);
    i2c_start();
    wr_byte(8'h90, ack);
    check("post_rst_addr_ack", 32'(ack), 32'd0);
    i2c_stop();

`ifdef I2C_TARGET_STRETCH_EN
    // SCL stretched until rd_vld arrives 50 cycles after rd_req
    rd_vld = 1'b0;
    fork
      begin
        logic       sack;
        logic [7:0] sd;
        i2c_start();
        wr_byte(8'h91, sack);
        check("st_addr_ack", 32'(sack), 32'd0);
        rd_byte(1'b1, sd);
        check("st_msb", 32'(sd), 32'h1A);
        i2c_stop();
      end
      begin : vld_driver
        int t = 0;
        while (rd_req_o !== 1'b1 && t < 5000) begin
          @(negedge clk);
          t++;
        end
        check("st_req_seen", 32'(rd_req_o), 32'd1);
        wait_clk(50);
        check("st_scl_held", 32'(scl_padoen_o), 32'd0);
        rd_vld = 1'b1;
        wait_clk(1);
        check("st_msb_driven", 32'(sda_padoen_o), 32'd0);
        check("st_scl_still_held", 32'(scl_padoen_o), 32'd0);
        wait_clk(1);
        check("st_scl_released", 32'(scl_padoen_o), 32'd1);
      end
    join
`else
    check("scl_never_driven", 32'(scl_low_seen), 32'd0);
`endif

    wait_clk(4);
    check("pulse_width_errors", 32'(width_err), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
